// File: rtl/note_envelope_ctrl_if.sv
// Note/envelope control bus: keypad and adder inputs,
// oscillator frequency, enveloped sample and status outputs.
interface note_envelope_ctrl_if;
  logic        sample_tick;
  logic [11:0] key_freq;
  logic [15:0] sig_in;
  logic [11:0] freq_out;
  logic [15:0] sig_out;
  logic [7:0]  env;
  logic [2:0]  state;
  logic        active;

  modport master (
    output sample_tick,
    output key_freq,
    output sig_in,
    input  freq_out,
    input  sig_out,
    input  env,
    input  state,
    input  active
  );

  modport slave (
    input  sample_tick,
    input  key_freq,
    input  sig_in,
    output freq_out,
    output sig_out,
    output env,
    output state,
    output active
  );
endinterface

// File: rtl/note_envelope_ctrl.sv
// Per-keypress note latch and ADSR envelope; scales the
// mixed signal by the envelope gain once per sample tick.
module note_envelope_ctrl #(
  parameter int unsigned ATTACK_STEP   = 16,
  parameter int unsigned DECAY_STEP    = 4,
  parameter int unsigned SUSTAIN_LEVEL = 192,
  parameter int unsigned RELEASE_STEP  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  note_envelope_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ATTACK  = 3'd1,
    DECAY   = 3'd2,
    SUSTAIN = 3'd3,
    RELEASE = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic [7:0]         env_q, env_d;
  logic [11:0]        freq_q, freq_d;
  logic [15:0]        sig_q, sig_d;

  logic               key_on;
  logic               new_key;
  logic               gated;
  logic [8:0]         att_sum;
  logic signed [9:0]  dec_dif;
  logic signed [9:0]  rel_dif;
  logic signed [24:0] prod;

  // State register; everything else only moves on a tick
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      env_q   <= '0;
      freq_q  <= '0;
      sig_q   <= '0;
    end else begin
      state_q <= state_d;
      env_q   <= env_d;
      freq_q  <= freq_d;
      sig_q   <= sig_d;
    end
  end

  // Next-state, envelope step and output scaling
  always_comb begin
    state_d = state_q;
    env_d   = env_q;
    freq_d  = freq_q;
    sig_d   = sig_q;
    key_on  = (bus.key_freq != '0);
    new_key = key_on && (bus.key_freq != freq_q);
    gated   = (state_q == ATTACK) ||
              (state_q == DECAY)  ||
              (state_q == SUSTAIN);
    att_sum = {1'b0, env_q} + 9'(ATTACK_STEP);
    dec_dif = $signed({2'b00, env_q}) -
              $signed(10'(DECAY_STEP));
    rel_dif = $signed({2'b00, env_q}) -
              $signed(10'(RELEASE_STEP));
    prod    = $signed(bus.sig_in) *
              $signed({1'b0, env_q});
    if (bus.sample_tick) begin
      sig_d = 16'(prod >>> 8);
      if (gated && !key_on) begin
        state_d = RELEASE;
      end else if (gated && new_key) begin
        freq_d  = bus.key_freq;
        state_d = ATTACK;
      end else begin
        unique case (state_q)
          IDLE: begin
            env_d = '0;
            if (key_on) begin
              freq_d  = bus.key_freq;
              state_d = ATTACK;
            end
          end
          ATTACK: begin
            if (att_sum >= 9'd255) begin
              env_d   = 8'hff;
              state_d = DECAY;
            end else begin
              env_d = att_sum[7:0];
            end
          end
          DECAY: begin
            if (dec_dif <= $signed(10'(SUSTAIN_LEVEL))) begin
              env_d   = 8'(SUSTAIN_LEVEL);
              state_d = SUSTAIN;
            end else begin
              env_d = dec_dif[7:0];
            end
          end
          SUSTAIN: begin
            env_d = env_q;
          end
          RELEASE: begin
            if (key_on) begin
              freq_d  = bus.key_freq;
              state_d = ATTACK;
            end else if (rel_dif <= 10'sd0) begin
              env_d   = '0;
              state_d = IDLE;
            end else begin
              env_d = rel_dif[7:0];
            end
          end
          default: begin
            env_d   = '0;
            state_d = IDLE;
          end
        endcase
      end
    end
  end

  assign bus.freq_out = freq_q;
  assign bus.sig_out  = sig_q;
  assign bus.env      = env_q;
  assign bus.state    = state_q;
  assign bus.active   = (state_q != IDLE);

endmodule

// File: tb/tb_note_envelope_ctrl.sv
// Scoreboard bench: directed ticks push expected outputs,
// a negedge monitor pops and compares, and checks holds.
module tb_note_envelope_ctrl;

  typedef struct {
    int          id;
    logic [11:0] f;
    logic [7:0]  e;
    logic [2:0]  s;
    logic [15:0] g;
  } exp_t;

  logic clk;
  logic rst;
  logic vld_q;
  int   checks;
  int   errors;
  int   n_id;
  bit   have_last;
  exp_t last;
  exp_t exp_q[$];

  note_envelope_ctrl_if bus ();

  note_envelope_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) vld_q <= bus.sample_tick | rst;

  task automatic compare(input exp_t e, input string tag);
    logic act_e;
    act_e = (e.s != 3'd0);
    checks++;
    if (bus.freq_out !== e.f || bus.env !== e.e ||
        bus.state !== e.s || bus.sig_out !== e.g ||
        bus.active !== act_e) begin
      errors++;
      $display("FAIL %s#%0d: got f=%0d e=%0d s=%0d sig=%0d act=%0b, want f=%0d e=%0d s=%0d sig=%0d act=%0b",
               tag, e.id, bus.freq_out, bus.env, bus.state,
               $signed(bus.sig_out), bus.active, e.f, e.e,
               e.s, $signed(e.g), act_e);
    end
  endtask

  always @(negedge clk) begin
    if (vld_q) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL underflow: output with no expectation");
      end else begin
        last = exp_q.pop_front();
        have_last = 1'b1;
        compare(last, "tick");
      end
    end else if (have_last) begin
      compare(last, "hold");
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int ef, input int ee,
                      input int es, input int esig);
    exp_t x;
    x.id = n_id;
    x.f  = 12'(ef);
    x.e  = 8'(ee);
    x.s  = 3'(es);
    x.g  = 16'(esig);
    n_id++;
    exp_q.push_back(x);
  endtask

  task automatic tick(input int key, input int sig,
                      input int ef, input int ee,
                      input int es, input int esig);
    bus.key_freq    = 12'(key);
    bus.sig_in      = 16'(sig);
    bus.sample_tick = 1'b1;
    push(ef, ee, es, esig);
    cyc();
    bus.sample_tick = 1'b0;
    repeat (7) cyc();
  endtask

  task automatic attack_decay(input int sig_att,
                              input int sig_first_dec);
    int ev;
    int sv;
    for (int t = 2; t <= 17; t++) begin
      ev = (16 * (t - 1) > 255) ? 255 : 16 * (t - 1);
      sv = (sig_att == 256) ? 16 * (t - 2) : 0;
      tick(440, sig_att, 440, ev, (t == 17) ? 2 : 1, sv);
    end
    for (int k = 1; k <= 16; k++) begin
      ev = (255 - 4 * k < 192) ? 192 : 255 - 4 * k;
      if (k == 1)
        tick(440, sig_first_dec, 440, ev, 2,
             (sig_first_dec == 16384) ? 16320 : 0);
      else
        tick(440, 0, 440, ev, (k == 16) ? 3 : 2, 0);
    end
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation timed out");
    $fatal(1);
  end

  initial begin
    checks    = 0;
    errors    = 0;
    n_id      = 0;
    have_last = 1'b0;
    vld_q     = 1'b0;
    // reset held with ticks and a key present
    rst             = 1'b1;
    bus.sample_tick = 1'b1;
    bus.key_freq    = 12'd440;
    bus.sig_in      = 16'd1000;
    for (int i = 0; i < 3; i++) begin
      push(0, 0, 0, 0);
      cyc();
    end
    rst             = 1'b0;
    bus.sample_tick = 1'b0;
    repeat (4) cyc();

    // attack to 255, decay to sustain; sig_in=256 shows env-before
    tick(440, 256, 440, 0, 1, 0);
    attack_decay(256, 16384);

    // release all the way to idle, pitch kept
    tick(0, -256, 440, 192, 4, -192);
    for (int k = 1; k <= 96; k++)
      tick(0, 0, 440, 192 - 2 * k, (k == 96) ? 0 : 4, 0);
    tick(0, 16384, 440, 0, 0, 0);

    // second note, up to sustain
    tick(440, 0, 440, 0, 1, 0);
    attack_decay(0, 0);

    // legato change in sustain: attack from 192
    tick(523, 0, 523, 192, 1, 0);
    tick(523, 0, 523, 208, 1, 0);
    tick(523, 0, 523, 224, 1, 0);
    tick(523, 0, 523, 240, 1, 0);
    tick(523, 0, 523, 255, 2, 0);
    tick(523, -32768, 523, 251, 2, -32640);
    for (int k = 2; k <= 16; k++)
      tick(523, 0, 523, (255 - 4 * k < 192) ? 192 : 255 - 4 * k,
           (k == 16) ? 3 : 2, 0);

    // release to 100 then retrigger same key
    tick(0, 0, 523, 192, 4, 0);
    for (int k = 1; k <= 46; k++)
      tick(0, 0, 523, 192 - 2 * k, 4, 0);
    tick(523, 0, 523, 100, 1, 0);
    tick(523, 0, 523, 116, 1, 0);

    // release then retrigger a different key
    tick(0, 0, 523, 116, 4, 0);
    tick(440, 0, 440, 116, 1, 0);
    tick(440, 0, 440, 132, 1, 0);

    // reset coincident with a tick mid-attack
    rst             = 1'b1;
    bus.sample_tick = 1'b1;
    bus.key_freq    = 12'd440;
    push(0, 0, 0, 0);
    cyc();
    rst             = 1'b0;
    bus.sample_tick = 1'b0;
    bus.key_freq    = 12'd0;
    repeat (3) cyc();

    // key pulses only between ticks
    bus.key_freq = 12'd440;
    repeat (3) cyc();
    bus.key_freq = 12'd0;
    cyc();
    tick(0, 0, 0, 0, 0, 0);

    repeat (3) cyc();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, want 0",
               exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
